// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the CPU sequencer and its decoder.
//   state_e        sequencer FSM states
//   instr_class_e  instruction class field encoding
//   alu_op_e       ALU operation field encoding
//   instr_t        decoded instruction fields
package cpu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMemRd,
        StMemWr,
        StWb,
        StHalt
    } state_e;

    typedef enum logic [1:0] {
        CLS_ALU   = 2'b00,
        CLS_LOAD  = 2'b01,
        CLS_STORE = 2'b10,
        CLS_HALT  = 2'b11
    } instr_class_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } alu_op_e;

    // Instruction word layout: [15:14] class, [13:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2.
    localparam int unsigned InstrWidth = 16;
    localparam int unsigned ClsLsb     = 14;
    localparam int unsigned OpLsb      = 12;
    localparam int unsigned RdLsb      = 8;
    localparam int unsigned Rs1Lsb     = 4;
    localparam int unsigned Rs2Lsb     = 0;
    localparam int unsigned RegFieldW  = 4;

    typedef struct packed {
        instr_class_e         cls;
        alu_op_e              op;
        logic [RegFieldW-1:0] rd;
        logic [RegFieldW-1:0] rs1;
        logic [RegFieldW-1:0] rs2;
    } instr_t;

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// cpu_seq_ctrl_if: bus and datapath handshake signals of the CPU sequencer.
//   Instruction read channel : instr_req/instr_addr -> instr_valid/instr_data
//   Data read channel        : rd_req/rd_addr -> rd_valid/rd_data
//   Data write channel       : wr_req/wr_addr/wr_data -> wr_ack
//   Datapath                 : rs1_sel/rs2_sel -> rs1_val/rs2_val, alu_op/alu_start ->
//                              alu_done/alu_result, rd_sel/rd_we/rd_wdata writeback
// modport master is the sequencer side, modport slave the memory/datapath side.
interface cpu_seq_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REG    = 16
);
    localparam int unsigned SelW = $clog2(NUM_REG);

    logic                  instr_req;
    logic [ADDR_WIDTH-1:0] instr_addr;
    logic                  instr_valid;
    logic [DATA_WIDTH-1:0] instr_data;

    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;

    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ack;

    logic [SelW-1:0]       rs1_sel;
    logic [SelW-1:0]       rs2_sel;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;

    logic [1:0]            alu_op;
    logic                  alu_start;
    logic                  alu_done;
    logic [DATA_WIDTH-1:0] alu_result;

    logic [SelW-1:0]       rd_sel;
    logic                  rd_we;
    logic [DATA_WIDTH-1:0] rd_wdata;

    modport master (
        output instr_req, instr_addr,
        input  instr_valid, instr_data,
        output rd_req, rd_addr,
        input  rd_valid, rd_data,
        output wr_req, wr_addr, wr_data,
        input  wr_ack,
        output rs1_sel, rs2_sel,
        input  rs1_val, rs2_val,
        output alu_op, alu_start,
        input  alu_done, alu_result,
        output rd_sel, rd_we, rd_wdata
    );

    modport slave (
        input  instr_req, instr_addr,
        output instr_valid, instr_data,
        input  rd_req, rd_addr,
        output rd_valid, rd_data,
        input  wr_req, wr_addr, wr_data,
        output wr_ack,
        input  rs1_sel, rs2_sel,
        output rs1_val, rs2_val,
        input  alu_op, alu_start,
        output alu_done, alu_result,
        input  rd_sel, rd_we, rd_wdata
    );

endinterface

// File: rtl/cpu_instr_decode.sv
// cpu_instr_decode: combinational split of the instruction register into fields.
//   instr_i  instruction word
//   dec_o    decoded class, ALU op and register indices
module cpu_instr_decode
    import cpu_pkg::*;
(
    input  logic [InstrWidth-1:0] instr_i,
    output instr_t                dec_o
);

    always_comb begin
        dec_o.cls = instr_class_e'(instr_i[ClsLsb +: 2]);
        dec_o.op  = alu_op_e'(instr_i[OpLsb +: 2]);
        dec_o.rd  = instr_i[RdLsb +: RegFieldW];
        dec_o.rs1 = instr_i[Rs1Lsb +: RegFieldW];
        dec_o.rs2 = instr_i[Rs2Lsb +: RegFieldW];
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle sequencer for the 16-bit CPU datapath.
// Fetches, decodes and executes ALU / LOAD / STORE / HALT instructions one at a time.
//   clk          clock
//   rstn         asynchronous active-low reset
//   run          leaves IDLE when high (only examined in IDLE)
//   bus          cpu_seq_ctrl_if.master: instruction/data channels and datapath controls
//   halted       high once a HALT instruction has been decoded
//   retired_cnt  retired instruction count (only with CPU_SEQ_PERF_CNT_EN defined)
// Optional feature macro: CPU_SEQ_PERF_CNT_EN adds the retired_cnt counter and port.
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REG    = 16
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           run,
    cpu_seq_ctrl_if.master bus,
    output logic           halted
`ifdef CPU_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]    retired_cnt
`endif
);

    localparam int unsigned SelW = $clog2(NUM_REG);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [SelW-1:0]       rs1_sel_q, rs1_sel_d;
    logic [SelW-1:0]       rs2_sel_q, rs2_sel_d;
    alu_op_e               alu_op_q, alu_op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  start_pend_q, start_pend_d;

    logic                  instr_req;
    logic                  rd_req;
    logic                  wr_req;
    logic                  alu_start;
    logic                  rd_we;
    logic [SelW-1:0]       rs1_sel;
    logic [SelW-1:0]       rs2_sel;
    logic [SelW-1:0]       rd_sel;
    logic [1:0]            alu_op;

    instr_t                dec;

    cpu_instr_decode u_decode (
        .instr_i (ir_q[InstrWidth-1:0]),
        .dec_o   (dec)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            pc_q         <= '0;
            ir_q         <= '0;
            rs1_sel_q    <= '0;
            rs2_sel_q    <= '0;
            alu_op_q     <= OP_ADD;
            addr_q       <= '0;
            wdata_q      <= '0;
            res_q        <= '0;
            start_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            rs1_sel_q    <= rs1_sel_d;
            rs2_sel_q    <= rs2_sel_d;
            alu_op_q     <= alu_op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            res_q        <= res_d;
            start_pend_q <= start_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        rs1_sel_d    = rs1_sel_q;
        rs2_sel_d    = rs2_sel_q;
        alu_op_d     = alu_op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        res_d        = res_q;
        start_pend_d = start_pend_q;

        instr_req    = 1'b0;
        rd_req       = 1'b0;
        wr_req       = 1'b0;
        alu_start    = 1'b0;
        rd_we        = 1'b0;
        halted       = 1'b0;
        rd_sel       = '0;
        // Operand selects hold the value captured in the last DECODE.
        rs1_sel      = rs1_sel_q;
        rs2_sel      = rs2_sel_q;
        alu_op       = alu_op_q;

        case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StFetch;
                end
            end

            StFetch: begin
                instr_req = 1'b1;
                if (bus.instr_valid) begin
                    ir_d    = bus.instr_data;
                    pc_d    = pc_q + ADDR_WIDTH'(1);
                    state_d = StDecode;
                end
            end

            StDecode: begin
                // Selects go out combinationally so rs1_val/rs2_val are valid this cycle.
                rs1_sel      = SelW'(dec.rs1);
                rs2_sel      = SelW'(dec.rs2);
                alu_op       = dec.op;
                rs1_sel_d    = SelW'(dec.rs1);
                rs2_sel_d    = SelW'(dec.rs2);
                alu_op_d     = dec.op;
                addr_d       = ADDR_WIDTH'(bus.rs1_val);
                wdata_d      = bus.rs2_val;
                start_pend_d = 1'b1;
                case (dec.cls)
                    CLS_ALU:   state_d = StExec;
                    CLS_LOAD:  state_d = StMemRd;
                    CLS_STORE: state_d = StMemWr;
                    default:   state_d = StHalt;
                endcase
            end

            StExec: begin
                // Start pulses only on the first EXEC cycle; done may arrive in that cycle.
                alu_start    = start_pend_q;
                start_pend_d = 1'b0;
                if (bus.alu_done) begin
                    res_d   = bus.alu_result;
                    state_d = StWb;
                end
            end

            StMemRd: begin
                rd_req = 1'b1;
                if (bus.rd_valid) begin
                    res_d   = bus.rd_data;
                    state_d = StWb;
                end
            end

            StMemWr: begin
                wr_req = 1'b1;
                if (bus.wr_ack) begin
                    state_d = StFetch;
                end
            end

            StWb: begin
                rd_we   = 1'b1;
                rd_sel  = SelW'(dec.rd);
                state_d = StFetch;
            end

            StHalt: begin
                halted = 1'b1;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.instr_req  = instr_req;
    assign bus.instr_addr = pc_q;
    assign bus.rd_req     = rd_req;
    assign bus.rd_addr    = rd_req ? addr_q : '0;
    assign bus.wr_req     = wr_req;
    assign bus.wr_addr    = wr_req ? addr_q : '0;
    assign bus.wr_data    = wr_req ? wdata_q : '0;
    assign bus.rs1_sel    = rs1_sel;
    assign bus.rs2_sel    = rs2_sel;
    assign bus.alu_op     = alu_op;
    assign bus.alu_start  = alu_start;
    assign bus.rd_sel     = rd_sel;
    assign bus.rd_we      = rd_we;
    assign bus.rd_wdata   = rd_we ? res_q : '0;

`ifdef CPU_SEQ_PERF_CNT_EN
    logic [31:0] retired_q;
    logic        retire;

    // A writeback or an accepted store retires one instruction; HALT never counts.
    assign retire = (state_q == StWb) || ((state_q == StMemWr) && bus.wr_ack);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: self-checking bench for cpu_seq_ctrl. The bench plays memory and datapath
// (register file, ALU with programmable latency) and predicts every observable transaction
// from an instruction-level model of the program.
module tb_cpu_seq_ctrl;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic run = 1'b0;
    logic run_s = 1'b0;
    logic halted;
    logic halted_s;
`ifdef CPU_SEQ_PERF_CNT_EN
    logic [31:0] retired_cnt;
    logic [31:0] retired_cnt_s;
`endif

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned exp_ret = 0;
    int unsigned fetches_s = 0;
    logic [15:0] pc_model = 16'h0000;
    logic [15:0] regs [16];

    always #5 clk = ~clk;

    cpu_seq_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .NUM_REG(16)) bus ();
    cpu_seq_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .NUM_REG(16)) bus_s ();

    cpu_seq_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .NUM_REG(16)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .run         (run),
        .bus         (bus.master),
        .halted      (halted)
`ifdef CPU_SEQ_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt)
`endif
    );

    // Narrow-PC instance: runs 15 stores then HALT at the all-ones address to show PC wrap.
    cpu_seq_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .NUM_REG(16)) dut_s (
        .clk         (clk),
        .rstn        (rstn),
        .run         (run_s),
        .bus         (bus_s.master),
        .halted      (halted_s)
`ifdef CPU_SEQ_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt_s)
`endif
    );

    function automatic logic [15:0] alu_fn(input logic [1:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a * b;
            default: return (b == 16'd0) ? 16'hFFFF : a / b;
        endcase
    endfunction

    // Datapath model for the main instance.
    assign bus.rs1_val    = regs[bus.rs1_sel];
    assign bus.rs2_val    = regs[bus.rs2_sel];
    assign bus.alu_result = alu_fn(bus.alu_op, bus.rs1_val, bus.rs2_val);

    // Zero-wait responder for the narrow instance.
    assign bus_s.instr_valid = 1'b1;
    assign bus_s.instr_data  = (bus_s.instr_addr == 4'hF) ? 16'hC000 : 16'h8000;
    assign bus_s.rd_valid    = 1'b0;
    assign bus_s.rd_data     = 16'h0000;
    assign bus_s.wr_ack      = 1'b1;
    assign bus_s.rs1_val     = 16'h0000;
    assign bus_s.rs2_val     = 16'h0000;
    assign bus_s.alu_done    = 1'b0;
    assign bus_s.alu_result  = 16'h0000;

    always @(posedge clk) begin
        if (bus_s.instr_req && bus_s.instr_valid) fetches_s <= fetches_s + 1;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk1("one_req", $countones({bus.instr_req, bus.rd_req, bus.wr_req}) <= 1, 1'b1);
    endtask

    // Runs one instruction through the DUT; lat = wait cycles on fetch and on the unit/memory.
    task automatic do_instr(input logic [15:0] instr, input int unsigned lat);
        logic [1:0]  cls;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_val;
        cls = instr[15:14];
        rd  = instr[11:8];
        rs1 = instr[7:4];
        rs2 = instr[3:0];

        for (int i = 0; i < 8 && bus.instr_req !== 1'b1; i++) tick();
        for (int k = 0; k <= int'(lat); k++) begin
            chk1("fetch_req", bus.instr_req, 1'b1);
            chkw("fetch_addr", 32'(bus.instr_addr), 32'(pc_model));
            bus.instr_data  = instr;
            bus.instr_valid = (k == int'(lat));
            tick();
        end
        bus.instr_valid = 1'b0;
        pc_model = pc_model + 16'd1;

        // DECODE cycle
        chkw("dec_rs1", 32'(bus.rs1_sel), 32'(rs1));
        chkw("dec_rs2", 32'(bus.rs2_sel), 32'(rs2));
        chkw("dec_op", 32'(bus.alu_op), 32'(instr[13:12]));
        chk1("dec_noreq", bus.instr_req | bus.rd_req | bus.wr_req, 1'b0);
        a = regs[rs1];
        b = regs[rs2];
        tick();

        case (cls)
            2'd0: begin
                exp_val = alu_fn(instr[13:12], a, b);
                for (int k = 0; k <= int'(lat); k++) begin
                    chk1("alu_start", bus.alu_start, k == 0);
                    chk1("exec_no_we", bus.rd_we, 1'b0);
                    bus.alu_done = (k == int'(lat));
                    tick();
                end
                bus.alu_done = 1'b0;
            end
            2'd1: begin
                exp_val = 16'($urandom);
                for (int k = 0; k <= int'(lat); k++) begin
                    chk1("rd_req", bus.rd_req, 1'b1);
                    chkw("rd_addr", 32'(bus.rd_addr), 32'(a));
                    chk1("load_no_we", bus.rd_we, 1'b0);
                    bus.rd_data  = exp_val;
                    bus.rd_valid = (k == int'(lat));
                    tick();
                end
                bus.rd_valid = 1'b0;
            end
            2'd2: begin
                exp_val = 16'h0000;
                for (int k = 0; k <= int'(lat); k++) begin
                    chk1("wr_req", bus.wr_req, 1'b1);
                    chkw("wr_addr", 32'(bus.wr_addr), 32'(a));
                    chkw("wr_data", 32'(bus.wr_data), 32'(b));
                    chk1("store_no_we", bus.rd_we, 1'b0);
                    bus.wr_ack = (k == int'(lat));
                    tick();
                end
                bus.wr_ack = 1'b0;
                chk1("store_no_wb", bus.rd_we, 1'b0);
                exp_ret++;
            end
            default: begin
                exp_val = 16'h0000;
                for (int k = 0; k < 3; k++) begin
                    chk1("halted", halted, 1'b1);
                    chk1("halt_noreq", bus.instr_req | bus.rd_req | bus.wr_req, 1'b0);
                    chkw("halt_pc", 32'(bus.instr_addr), 32'(pc_model));
                    tick();
                end
            end
        endcase

        if (cls == 2'd0 || cls == 2'd1) begin
            chk1("wb_we", bus.rd_we, 1'b1);
            chkw("wb_sel", 32'(bus.rd_sel), 32'(rd));
            chkw("wb_data", 32'(bus.rd_wdata), 32'(exp_val));
            regs[rd] = exp_val;
            exp_ret++;
            tick();
            chk1("wb_one_cycle", bus.rd_we, 1'b0);
        end
`ifdef CPU_SEQ_PERF_CNT_EN
        chkw("retired_cnt", retired_cnt, exp_ret);
`endif
    endtask

    initial begin
        logic [15:0] instr;
        bus.instr_valid = 1'b0;
        bus.instr_data  = 16'h0000;
        bus.rd_valid    = 1'b0;
        bus.rd_data     = 16'h0000;
        bus.wr_ack      = 1'b0;
        bus.alu_done    = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
        regs[1] = 16'd5;
        regs[2] = 16'd7;

        repeat (2) @(negedge clk);
        chk1("rst_instr_req", bus.instr_req, 1'b0);
        chkw("rst_instr_addr", 32'(bus.instr_addr), 32'h0);
        chk1("rst_rd_req", bus.rd_req, 1'b0);
        chk1("rst_wr_req", bus.wr_req, 1'b0);
        chk1("rst_alu_start", bus.alu_start, 1'b0);
        chk1("rst_rd_we", bus.rd_we, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chkw("rst_sels", 32'({bus.rs1_sel, bus.rs2_sel, bus.rd_sel, bus.alu_op}), 32'h0);
        chkw("rst_data", 32'(bus.rd_wdata | bus.wr_data | bus.wr_addr | bus.rd_addr), 32'h0);

        rstn  = 1'b1;
        run   = 1'b1;
        run_s = 1'b1;

        do_instr(16'h0312, 0);                 // ADD r3 = r1 + r2 = 12
        do_instr(16'h3412, 5);                 // DIV r4, done 5 cycles after start
        regs[2] = 16'h0100;
        do_instr(16'h4520, 3);                 // LOAD r5 <= mem[0x0100]
        regs[1] = 16'h0200;
        regs[2] = 16'h1234;
        do_instr(16'h8012, 2);                 // STORE mem[0x0200] <= 0x1234

        for (int n = 0; n < 30; n++) begin
            instr = 16'($urandom);
            instr[15:14] = 2'($urandom_range(0, 2));
            do_instr(instr, $urandom_range(0, 3));
        end
        do_instr(16'hC000, 1);

        // Narrow instance: PC wrapped past all-ones and stayed quiet in HALT.
        chk1("wrap_halted", halted_s, 1'b1);
        chkw("wrap_fetches", fetches_s, 32'd16);
        chkw("wrap_pc", 32'(bus_s.instr_addr), 32'h0);
        chk1("wrap_noreq", bus_s.instr_req | bus_s.rd_req | bus_s.wr_req, 1'b0);

        // Reset pulsed while a fetch is outstanding.
        rstn = 1'b0;
        #1;
        rstn = 1'b1;
        exp_ret  = 0;
        pc_model = 16'h0000;
        tick();
        tick();
        chk1("refetch_req", bus.instr_req, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk1("async_rst_req", bus.instr_req, 1'b0);
        chkw("async_rst_pc", 32'(bus.instr_addr), 32'h0);
        chk1("async_rst_halted", halted, 1'b0);
        bus.instr_valid = 1'b1;                // late valid must be ignored
        bus.instr_data  = 16'h0312;
        run = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        tick();
        chk1("idle_ignores_valid", bus.instr_req, 1'b0);
        chk1("idle_no_we", bus.rd_we, 1'b0);
        chkw("idle_pc", 32'(bus.instr_addr), 32'h0);
        bus.instr_valid = 1'b0;
        run = 1'b1;
        do_instr(16'h0312, 0);
        do_instr(16'hC000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
